// File: rtl/dds_phase_gen.sv
// DDS phase generator: phase accumulator plus phase offset; the top address
// bits drive the waveform ROM. Frequency/phase updates are held in a shadow
// and applied at the accumulator wrap.
// Optional feature: define DDS_PHASE_DITHER_EN to add LFSR dither before
// the address truncation.
module dds_phase_gen #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  cfg_freq_word,
  input  logic [ACC_W-1:0]  cfg_phase_off,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              addr_valid,
  output logic              wrap_pulse
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PENDING
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_fw;
  logic [ACC_W-1:0]    r_off;
  logic [ACC_W-1:0]    r_sh_fw;
  logic [ACC_W-1:0]    r_sh_off;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic                r_addr_valid;
  logic                r_wrap;

  logic                w_run;
  logic                w_accept;
  logic [ACC_W:0]      w_sum;
  logic                w_carry;
  logic [ACC_W-1:0]    w_phase;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_load_cfg;
  logic                w_load_sh;
  logic                w_apply_sh;

  assign w_run    = (r_state != S_IDLE) && enable;
  assign w_accept = cfg_valid && cfg_ready;
  assign w_sum    = {1'b0, r_acc} + {1'b0, r_fw};
  assign w_carry  = w_sum[ACC_W];

`ifdef DDS_PHASE_DITHER_EN
  localparam int unsigned DW = ((ACC_W - ADDR_W) > 16) ? 16 : (ACC_W - ADDR_W);

  logic [15:0]      r_lfsr;
  logic             w_lfsr_fb;
  logic [ACC_W-1:0] w_dith;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3];
  assign w_dith    = ACC_W'(r_lfsr[DW-1:0]);
  assign w_phase   = r_acc + r_off + w_dith;

  // Dither LFSR advances only while the accumulator runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else if (w_run) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end
`else
  assign w_phase = r_acc + r_off;
`endif

  // Shift rather than slice so every bit of the phase sum is consumed
  assign w_addr = ADDR_W'(w_phase >> (ACC_W - ADDR_W));

  // Config handshake is only blocked while a shadow update is waiting
  always_comb begin
    cfg_ready = (r_state != S_PENDING);
  end

  // Next-state and config-routing decisions
  always_comb begin
    w_state_nxt = r_state;
    w_load_cfg  = 1'b0;
    w_load_sh   = 1'b0;
    w_apply_sh  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load_cfg = w_accept;
        if (enable) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!enable) begin
          w_load_cfg  = w_accept;
          w_state_nxt = S_IDLE;
        end else if (w_accept) begin
          w_load_sh   = 1'b1;
          w_state_nxt = S_PENDING;
        end
      end
      S_PENDING: begin
        if (!enable) begin
          w_apply_sh  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_carry || (r_fw == '0)) begin
          w_apply_sh  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Active and shadow frequency/offset registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fw     <= '0;
      r_off    <= '0;
      r_sh_fw  <= '0;
      r_sh_off <= '0;
    end else begin
      if (w_load_cfg) begin
        r_fw  <= cfg_freq_word;
        r_off <= cfg_phase_off;
      end else if (w_apply_sh) begin
        r_fw  <= r_sh_fw;
        r_off <= r_sh_off;
      end
      if (w_load_sh) begin
        r_sh_fw  <= cfg_freq_word;
        r_sh_off <= cfg_phase_off;
      end
    end
  end

  // Accumulator and registered ROM-side outputs; rom_addr holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_rom_addr   <= '0;
      r_addr_valid <= 1'b0;
      r_wrap       <= 1'b0;
    end else if (w_run) begin
      r_acc        <= w_sum[ACC_W-1:0];
      r_rom_addr   <= w_addr;
      r_addr_valid <= 1'b1;
      r_wrap       <= w_carry;
    end else begin
      r_acc        <= '0;
      r_addr_valid <= 1'b0;
      r_wrap       <= 1'b0;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign addr_valid = r_addr_valid;
  assign wrap_pulse = r_wrap;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Self-checking bench for dds_phase_gen: directed scenarios followed by
// randomized traffic, all compared against a cycle-level arithmetic model.
module tb_dds_phase_gen;

  localparam int unsigned ACC_W  = 32;
  localparam int unsigned ADDR_W = 10;
  localparam longint unsigned MOD = 64'h1_0000_0000;
  localparam int unsigned SHIFT = ACC_W - ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [ACC_W-1:0]  cfg_freq_word = '0;
  logic [ACC_W-1:0]  cfg_phase_off = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic              addr_valid;
  logic              wrap_pulse;

  always #5 clk = ~clk;

  dds_phase_gen #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_freq_word (cfg_freq_word),
    .cfg_phase_off (cfg_phase_off),
    .rom_addr      (rom_addr),
    .addr_valid    (addr_valid),
    .wrap_pulse    (wrap_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: running flag, pending flag, plain integer registers
  bit              m_run, m_pend;
  longint unsigned m_acc, m_fw, m_off, m_sfw, m_soff;
  longint unsigned e_addr;
  bit              e_av, e_wr;
  longint unsigned m_lfsr;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pend = 0;
    m_acc = 0; m_fw = 0; m_off = 0; m_sfw = 0; m_soff = 0;
    e_addr = 0; e_av = 0; e_wr = 0;
    m_lfsr = 64'hACE1;
  endtask

  function automatic bit carry_next();
    return m_run && !m_pend && ((m_acc + m_fw) >= MOD);
  endfunction

  // One clock: drive inputs, check cfg_ready, advance model, check outputs
  task automatic step(input bit en, input bit v, input longint unsigned f, input longint unsigned o);
    bit              acc_ok;
    longint unsigned sum, dith, fb;
    bit              carry;
    enable        = en;
    cfg_valid     = v;
    cfg_freq_word = f[ACC_W-1:0];
    cfg_phase_off = o[ACC_W-1:0];
    #1;
    check("cfg_ready", cfg_ready, !m_pend);
    acc_ok = v && !m_pend;
    if (!m_run) begin
      if (acc_ok) begin m_fw = f; m_off = o; end
      m_acc = 0; e_av = 0; e_wr = 0; m_run = en;
    end else if (!en) begin
      if (m_pend) begin m_fw = m_sfw; m_off = m_soff; end
      else if (acc_ok) begin m_fw = f; m_off = o; end
      m_acc = 0; e_av = 0; e_wr = 0; m_run = 0; m_pend = 0;
    end else begin
      sum   = m_acc + m_fw;
      carry = (sum >= MOD);
`ifdef DDS_PHASE_DITHER_EN
      dith = m_lfsr & 64'hFFFF;
      fb = ((m_lfsr >> 15) ^ (m_lfsr >> 14) ^ (m_lfsr >> 12) ^ (m_lfsr >> 3)) & 1;
      m_lfsr = ((m_lfsr << 1) & 64'hFFFF) | fb;
`else
      dith = 0;
      fb = 0;
`endif
      e_addr = ((m_acc + m_off + dith) % MOD) >> SHIFT;
      m_acc  = sum % MOD;
      e_av   = 1;
      e_wr   = carry;
      if (m_pend) begin
        if (carry || m_fw == 0) begin
          m_fw = m_sfw; m_off = m_soff; m_pend = 0;
        end
      end else if (acc_ok) begin
        m_sfw = f; m_soff = o; m_pend = 1;
      end
    end
    @(posedge clk);
    #1;
    check("rom_addr", rom_addr, e_addr);
    check("addr_valid", addr_valid, e_av);
    check("wrap_pulse", wrap_pulse, e_wr);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  initial begin
    longint unsigned f, o;
    int              sel;
    bit              found;

    model_reset();
    #1;
    check("rst_rom_addr", rom_addr, 0);
    check("rst_addr_valid", addr_valid, 0);
    check("rst_wrap", wrap_pulse, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: configure in IDLE, then run past one wrap (period 256)
    step(0, 1, 64'h0100_0000, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("t1_first_valid", addr_valid, 1);
`ifndef DDS_PHASE_DITHER_EN
    check("t1_first_addr", rom_addr, 0);
    step(1, 0, 0, 0);
    check("t1_second_addr", rom_addr, 4);
`endif
    run(260);

    // 2: mid-period frequency change waits for the wrap
    run(50);
    step(1, 1, 64'h0200_0000, 0);
    check("t2_pending", cfg_ready, 0);
    run(260);

    // 3: config accepted on the same edge as the carry
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (carry_next()) found = 1;
      else step(1, 0, 0, 0);
    end
    check("t3_carry_found", found, 1);
    step(1, 1, 64'h0300_0000, 64'h1000_0000);
    check("t3_wrap_and_accept", wrap_pulse, 1);
    run(300);

    // 4: fw=0 running, new config applied on the next cycle
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    run(5);
    step(1, 1, 64'h0040_0000, 64'h8000_0000);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
`ifndef DDS_PHASE_DITHER_EN
    check("t4_jump", rom_addr, 512);
    step(1, 0, 0, 0);
    check("t4_inc", rom_addr, 513);
`endif
    run(3);

    // 5: enable drops while pending; shadow applied on the way to IDLE
    step(1, 1, 64'h0100_0000, 64'h4000_0000);
    step(0, 0, 0, 0);
    check("t5_idle_valid", addr_valid, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
`ifndef DDS_PHASE_DITHER_EN
    check("t5_first_addr", rom_addr, 256);
`endif
    run(20);

    // 6: asynchronous reset mid-run, between clock edges
    step(1, 1, 64'h0001_0000, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_rom_addr", rom_addr, 0);
    check("t6_addr_valid", addr_valid, 0);
    check("t6_wrap", wrap_pulse, 0);
    check("t6_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: f = 0;
        1: f = 64'h8000_0000;
        2: f = longint'($urandom);
        3: f = longint'($urandom >> 4);
        4: f = longint'($urandom_range(1, 64)) << 22;
        default: f = longint'($urandom >> 2);
      endcase
      o = longint'($urandom);
      step(($urandom_range(0, 99) < 95), ($urandom_range(0, 99) < 6), f, o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
